// File: rtl/rf_pkg.sv
// Shared sizing defaults for the scoreboarded register file.
package rf_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_NUM_READ = 2;
  localparam int RF_PEND_W   = 2;

  function automatic int pend_max(input int w);
    return (1 << w) - 1;
  endfunction

  localparam int DEPTH    = 2 ** RF_ADDR_W;
  localparam int PEND_MAX = pend_max(RF_PEND_W);

endpackage

// File: rtl/rf_pending_ctr.sv
// Per-register outstanding-write counters: reservations count up, write-backs count down.
module rf_pending_ctr
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int PEND_W = RF_PEND_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reserve_valid,
  input  logic [ADDR_W-1:0]     reserve_address,
  input  logic                  retire_valid,
  input  logic [ADDR_W-1:0]     retire_address,
  input  logic                  flush,
  output logic [2**ADDR_W-1:0]  busy,
  output logic [2**ADDR_W-1:0]  at_max,
  output logic [2**ADDR_W-1:0]  drain
);

  localparam int WORDS = 2 ** ADDR_W;
  localparam logic [PEND_W-1:0] MAX_CNT = PEND_W'(pend_max(PEND_W));

  logic [PEND_W-1:0] cnt_q [WORDS];
  logic [PEND_W-1:0] cnt_d [WORDS];
  logic [WORDS-1:0]  inc;
  logic [WORDS-1:0]  dec;

  // Register 0 never accumulates a reservation, so its counter stays at zero.
  always_comb begin
    for (int i = 0; i < WORDS; i++) begin
      inc[i]    = reserve_valid && !flush && (reserve_address == ADDR_W'(i)) && (i != 0);
      dec[i]    = retire_valid && (retire_address == ADDR_W'(i)) && (cnt_q[i] != '0);
      busy[i]   = (cnt_q[i] != '0);
      at_max[i] = (cnt_q[i] == MAX_CNT);
      drain[i]  = dec[i] && !inc[i] && (cnt_q[i] == PEND_W'(1));
      cnt_d[i]  = cnt_q[i];
      if (flush) begin
        cnt_d[i] = '0;
      end else if (inc[i] && !dec[i]) begin
        cnt_d[i] = cnt_q[i] + PEND_W'(1);
      end else if (dec[i] && !inc[i]) begin
        cnt_d[i] = cnt_q[i] - PEND_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WORDS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with write-back bypass and pending-write busy tracking.
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_READ = RF_NUM_READ,
  parameter int PEND_W   = RF_PEND_W,
  parameter int BYPASS   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_READ*ADDR_W-1:0]   in_read_address,
  output logic [NUM_READ*DATA_W-1:0]   out_read_data,
  output logic [NUM_READ-1:0]          out_read_busy,
  input  logic                         in_write_enable,
  input  logic [ADDR_W-1:0]            in_write_address,
  input  logic [DATA_W-1:0]            in_write_data,
  input  logic                         in_reserve_enable,
  input  logic [ADDR_W-1:0]            in_reserve_address,
  output logic                         out_reserve_ready,
  input  logic                         in_flush
);

  localparam int WORDS = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [WORDS];
  logic [DATA_W-1:0] mem_d [WORDS];
  logic [WORDS-1:0]  busy_vec;
  logic [WORDS-1:0]  at_max_vec;
  logic [WORDS-1:0]  drain_vec;
  logic              reserve_accept;

  // A full counter can still take a reservation when a write-back frees a slot in the same edge.
  always_comb begin
    out_reserve_ready = !(at_max_vec[in_reserve_address] &&
                          !(in_write_enable && (in_write_address == in_reserve_address)));
    reserve_accept    = in_reserve_enable && out_reserve_ready;
  end

  always_comb begin
    for (int i = 0; i < WORDS; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (in_write_enable && (in_write_address != '0)) begin
      mem_d[in_write_address] = in_write_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WORDS; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  rf_pending_ctr #(
    .ADDR_W (ADDR_W),
    .PEND_W (PEND_W)
  ) u_pending (
    .clk             (clk),
    .reset           (reset),
    .reserve_valid   (reserve_accept),
    .reserve_address (in_reserve_address),
    .retire_valid    (in_write_enable),
    .retire_address  (in_write_address),
    .flush           (in_flush),
    .busy            (busy_vec),
    .at_max          (at_max_vec),
    .drain           (drain_vec)
  );

  for (genvar k = 0; k < NUM_READ; k++) begin : g_read
    logic [ADDR_W-1:0] rd_addr;
    assign rd_addr = in_read_address[k*ADDR_W +: ADDR_W];

    // drain marks the write-back that empties the counter this edge, hiding busy early.
    always_comb begin
      out_read_data[k*DATA_W +: DATA_W] = mem_q[rd_addr];
      out_read_busy[k]                  = busy_vec[rd_addr];
      if (rd_addr == '0) begin
        out_read_data[k*DATA_W +: DATA_W] = '0;
      end else if ((BYPASS != 0) && in_write_enable && (in_write_address == rd_addr)) begin
        out_read_data[k*DATA_W +: DATA_W] = in_write_data;
      end
      if ((BYPASS != 0) && drain_vec[rd_addr]) begin
        out_read_busy[k] = 1'b0;
      end
    end
  end

endmodule
